// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a systolic cell chain: feeds beats into the chain head, tracks them through
// a fixed-latency pipeline and buffers tail results in a credit-protected FWFT FIFO.
module systolic_seq_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  job_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_c,
    output logic [31:0] arr_c,
    output logic [31:0] arr_x,
    output logic        arr_s,
    input  logic [31:0] arr_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [7:0]        beats_left_q, beats_left_d;
    logic              first_q, first_d;
    logic              zdone_q, zdone_d;
    logic              issue_q, issue_d;
    logic [31:0]       arr_c_q, arr_c_d;
    logic [31:0]       arr_x_q, arr_x_d;
    logic              arr_s_q, arr_s_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH:0]    vld_ext;
    logic [CW-1:0]     in_flight_q, in_flight_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW:0]       used;
    logic [31:0]       mem [FIFO_DEPTH];
    logic              accept, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both beats still in the chain and results parked in the FIFO.
    assign used      = {1'b0, in_flight_q} + {1'b0, cnt_q};
    assign in_ready  = (state_q == StRun) && (used < (CW + 1)'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = vld_q[DEPTH-1];
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rptr_q] : 32'd0;
    assign arr_c     = arr_c_q;
    assign arr_x     = arr_x_q;
    assign arr_s     = arr_s_q;
    assign busy      = (state_q != StIdle);
    assign done      = zdone_q || ((state_q == StDrain) && (in_flight_q == '0));

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        first_d      = first_q;
        zdone_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (job_len != 8'd0) begin
                        state_d      = StRun;
                        beats_left_d = job_len;
                        first_d      = 1'b1;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    beats_left_d = beats_left_q - 8'd1;
                    first_d      = 1'b0;
                    if (beats_left_q == 8'd1) state_d = StDrain;
                end
            end
            StDrain: begin
                if (in_flight_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue_d = accept;
        arr_c_d = accept ? in_c : 32'd0;
        arr_x_d = accept ? in_x : 32'd0;
        arr_s_d = accept && first_q;
        vld_ext = {vld_q, issue_q};
        vld_d   = vld_ext[DEPTH-1:0];

        in_flight_d = in_flight_q;
        unique case ({accept, push})
            2'b10:   in_flight_d = in_flight_q + CW'(1);
            2'b01:   in_flight_d = in_flight_q - CW'(1);
            default: in_flight_d = in_flight_q;
        endcase

        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beats_left_q <= 8'd0;
            first_q      <= 1'b0;
            zdone_q      <= 1'b0;
            issue_q      <= 1'b0;
            arr_c_q      <= 32'd0;
            arr_x_q      <= 32'd0;
            arr_s_q      <= 1'b0;
            vld_q        <= '0;
            in_flight_q  <= '0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            first_q      <= first_d;
            zdone_q      <= zdone_d;
            issue_q      <= issue_d;
            arr_c_q      <= arr_c_d;
            arr_x_q      <= arr_x_d;
            arr_s_q      <= arr_s_d;
            vld_q        <= vld_d;
            in_flight_q  <= in_flight_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wptr_q] <= arr_res;
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed scenarios plus random jobs, checked every cycle
// against a queue-based model of accepted beats and their result timing.
module tb_systolic_seq_ctrl;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  job_len;
    logic [31:0] in_x, in_c;
    logic        in_ready, arr_s, out_valid, busy, done;
    logic [31:0] arr_c, arr_x, arr_res, out_data;
    logic [31:0] tail_q [DEPTH];

    systolic_seq_ctrl #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .job_len(job_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_c(in_c),
        .arr_c(arr_c), .arr_x(arr_x), .arr_s(arr_s), .arr_res(arr_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cell chain stand-in: tail returns head x after DEPTH cycles.
    always @(posedge clk) begin
        tail_q[0] <= arr_x;
        for (int i = 1; i < DEPTH; i++) tail_q[i] <= tail_q[i-1];
    end
    assign arr_res = tail_q[DEPTH-1];

    typedef struct {
        int          cyc;
        logic [31:0] x;
    } res_t;

    res_t        q[$];
    int          n = 0;
    bit          job_active, first, zero_pend, prev_acc, prev_first;
    int          beats_rem;
    logic [31:0] prev_x, prev_c;
    int          acc_total, dut_acc, dut_pops, dut_dones;
    int          errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // Beats accepted but not yet written: write happens DEPTH+1 cycles after accept.
    function automatic int in_flight_m();
        int c = 0;
        foreach (q[i]) if (q[i].cyc + DEPTH + 1 >= n) c++;
        return c;
    endfunction

    task automatic step();
        logic e_ready, e_valid, e_done;
        logic [31:0] e_data;
        bit acc, pop, was_active;
        e_ready = job_active && beats_rem > 0 && q.size() < FIFO_DEPTH;
        e_valid = q.size() > 0 && (q[0].cyc + DEPTH + 2 <= n);
        e_data  = e_valid ? q[0].x : 32'd0;
        e_done  = zero_pend || (job_active && beats_rem == 0 && in_flight_m() == 0);
        chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
        chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        chk("out_data", out_data, e_data);
        chk("busy", {31'd0, busy}, {31'd0, job_active});
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("arr_x", arr_x, prev_acc ? prev_x : 32'd0);
        chk("arr_c", arr_c, prev_acc ? prev_c : 32'd0);
        chk("arr_s", {31'd0, arr_s}, {31'd0, prev_acc && prev_first});
        if (in_valid && in_ready) dut_acc++;
        if (out_valid && out_ready) dut_pops++;
        if (done) dut_dones++;
        acc = in_valid && e_ready;
        pop = e_valid && out_ready;
        prev_acc = acc; prev_first = first; prev_x = in_x; prev_c = in_c;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back('{cyc: n, x: in_x});
            beats_rem--;
            first = 1'b0;
            acc_total++;
        end
        was_active = job_active;
        zero_pend  = 1'b0;
        if (was_active && e_done) job_active = 1'b0;
        if (!was_active && start) begin
            if (job_len == 8'd0) zero_pend = 1'b1;
            else begin
                job_active = 1'b1;
                beats_rem  = int'(job_len);
                first      = 1'b1;
            end
        end
        @(posedge clk); #1;
        n++;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n++;
        rst = 1'b0;
        q.delete();
        job_active = 1'b0; beats_rem = 0; first = 1'b0; zero_pend = 1'b0; prev_acc = 1'b0;
    endtask

    task automatic start_job(input int len);
        start = 1'b1; job_len = 8'(len); in_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // Idle inputs until the job ends and the FIFO empties, then confirm the DUT is idle.
    task automatic drain_all();
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 80 && (job_active || zero_pend || q.size() > 0); k++) step();
        chk("drain_idle_busy", {31'd0, busy}, 32'd0);
        chk("drain_idle_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic random_job(input int len, input int vprob, input int rprob);
        start_job(len);
        for (int k = 0; k < 400 && job_active; k++) begin
            in_valid  = ($urandom_range(99) < vprob);
            in_x      = $urandom;
            in_c      = $urandom;
            out_ready = ($urandom_range(99) < rprob);
            step();
        end
        drain_all();
    endtask

    logic [31:0] bx [3];
    logic [31:0] bc [3];
    int          idx, prev;

    initial begin
        rst = 1'b1; start = 1'b0; job_len = 8'd0; in_valid = 1'b0;
        in_x = 32'd0; in_c = 32'd0; out_ready = 1'b1;
        acc_total = 0;
        repeat (2) @(posedge clk);
        do_reset();
        step();
        step();

        // Basic job
        bx[0] = 32'd5; bx[1] = 32'd7; bx[2] = 32'd1;
        bc[0] = 32'd2; bc[1] = 32'd3; bc[2] = 32'd4;
        dut_dones = 0; dut_pops = 0;
        start_job(3);
        idx = 0;
        for (int k = 0; k < 20 && idx < 3; k++) begin
            in_valid = 1'b1; in_x = bx[idx]; in_c = bc[idx];
            prev = acc_total;
            step();
            if (acc_total != prev) idx++;
        end
        drain_all();
        chk("basic_done_count", dut_dones, 32'd1);
        chk("basic_results", dut_pops, 32'd3);

        // Backpressure
        dut_acc = 0; dut_pops = 0;
        out_ready = 1'b0;
        start_job(20);
        for (int k = 0; k < 15; k++) begin
            in_valid = 1'b1; in_x = $urandom; in_c = $urandom;
            step();
        end
        chk("bp_accepted", dut_acc, 32'd8);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 200 && job_active; k++) begin
            in_valid = 1'b1; in_x = $urandom; in_c = $urandom;
            step();
        end
        drain_all();
        chk("bp_total_accepted", dut_acc, 32'd20);
        chk("bp_total_results", dut_pops, 32'd20);

        // Bubbles
        start_job(4);
        for (int k = 0; k < 40 && job_active; k++) begin
            in_valid = (k % 2 == 0); in_x = $urandom | 32'd1; in_c = $urandom | 32'd1;
            step();
        end
        drain_all();

        // Zero length
        dut_dones = 0;
        start_job(0);
        for (int k = 0; k < 4; k++) step();
        chk("zero_done_count", dut_dones, 32'd1);

        // Ignored start during RUN
        dut_acc = 0;
        start_job(5);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_x = $urandom; in_c = $urandom;
            step();
        end
        start = 1'b1; job_len = 8'd9;
        step();
        start = 1'b0;
        for (int k = 0; k < 40 && job_active; k++) begin
            in_valid = 1'b1; in_x = $urandom; in_c = $urandom;
            step();
        end
        drain_all();
        chk("ignored_start_beats", dut_acc, 32'd5);

        // Reset mid-job with three beats in flight
        dut_pops = 0;
        out_ready = 1'b0;
        start_job(6);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_x = $urandom; in_c = $urandom;
            step();
        end
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("reset_no_results", dut_pops, 32'd0);
        random_job(7, 70, 80);

        // Random jobs
        for (int j = 0; j < 6; j++)
            random_job(int'($urandom_range(30, 1)), int'($urandom_range(90, 30)),
                       int'($urandom_range(90, 20)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4, cycles from arr_* driven at the chain head to the matching result on arr_res (at least 1).
- FIFO_DEPTH, 8, result FIFO entries (at least 1).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job start pulse; sampled only in IDLE.
- job_len  in  8  number of beats in the job; latched on accepted start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- in_x  in  32  beat x operand.
- in_c  in  32  beat coefficient.
- arr_c  out  32  coefficient to the cell-chain head.
- arr_x  out  32  x to the cell-chain head.
- arr_s  out  1  mode/select to the cell-chain head.
- arr_res  in  32  x output from the chain tail.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_data  out  32  result word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job completion.

Function
REQ-003 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-004 IDLE to RUN SHALL occur on start=1 with job_len!=0; job_len is latched into beats_left.
REQ-005 start=1 with job_len=0 in IDLE SHALL pulse done on the next cycle, issue no beats, and stay in IDLE.
REQ-006 RUN to DRAIN SHALL occur on the cycle the last beat is accepted (beats_left 1 to 0).
REQ-007 DRAIN to IDLE SHALL occur when in_flight==0; done SHALL pulse high in that same transition cycle.
REQ-008 in_ready SHALL be combinational: (state==RUN) and (in_flight + fifo_count < FIFO_DEPTH).
REQ-009 arr_c, arr_x and arr_s SHALL be registered; a beat accepted in cycle t SHALL appear on them in cycle t+1.
REQ-010 arr_s SHALL be 1 only for the first beat of a job and 0 for all later beats.
REQ-011 Cycles with no accepted beat SHALL drive a bubble next cycle: arr_c=0, arr_x=0, arr_s=0. This leaves cell state unchanged.
REQ-012 A DEPTH-bit valid shift register SHALL track issued beats. A beat driven in cycle t+1 SHALL be sampled from arr_res at cycle t+1+DEPTH and written to the FIFO.
REQ-013 in_flight SHALL count beats that are accepted but not yet written to the FIFO. Simultaneous accept and write SHALL leave it unchanged.
REQ-014 FIFO SHALL be first-word-fall-through after the write cycle: out_valid rises the cycle after the write.
REQ-015 FIFO SHALL pop on out_valid and out_ready. A simultaneous push and pop SHALL keep fifo_count unchanged, and order SHALL be preserved.
REQ-016 The credit rule in REQ-008 SHALL guarantee that the FIFO never overflows and that no result is dropped when out_ready is held low indefinitely.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 start SHALL be ignored in RUN and DRAIN.
REQ-019 Results still in the FIFO after done SHALL remain poppable.
REQ-020 A new job SHALL be allowed to start while the FIFO is still non-empty.

Reset
REQ-021 On rst=1 at a clock edge, the following SHALL be cleared:
- state to IDLE;
- beats_left, in_flight, the valid shift register, and the FIFO pointers and count to 0;
- in_ready, arr_c, arr_x, arr_s, out_valid, out_data, busy and done to 0.
REQ-022 Reset mid-job SHALL abandon the job: queued results are discarded and no done is produced.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic job: DEPTH=4, job_len=3, beats (c,x)=(2,5),(3,7),(4,1), out_ready=1, tail modelled by a 4-stage delay of arr_x. Required: arr_s sequence 1,0,0; out_data 5,7,1 starting at the accept cycle of beat 1 plus 6; done once; busy falls with done.
- Backpressure: FIFO_DEPTH=8, job_len=20, out_ready=0. Required: exactly 8 beats accepted, then in_ready=0. After out_ready=1, all 20 results arrive in order with none lost.
- Bubbles: job_len=4 with in_valid toggled 1,0,1,0,... Required: arr_c, arr_x and arr_s are all 0 in bubble cycles, and only the first real beat has arr_s=1.
- Zero length: start with job_len=0. Required: done on the next cycle, busy stays 0, no arr activity.
- Ignored start: start pulsed during RUN with job_len=9. Required: no effect, and beats_left keeps the original count.
- Reset mid-job: rst during RUN with 3 beats in flight. Required: all outputs 0 on the next cycle, out_valid never asserts for the abandoned beats, and a fresh job then completes normally.
